// File: rtl/psum_out_fifo.sv
// Output buffer for finished partial sums: synchronous FIFO with a registered
// read port and count-decoded status flags for the write controller's stall logic.
module psum_out_fifo #(
   parameter int  DATA_W   = 16,
   parameter int  DEPTH    = 8,
   localparam int ADDR_W   = $clog2(DEPTH),
   parameter int  AF_LEVEL = DEPTH - 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              outbuf_write,
   input  logic [DATA_W-1:0] wr_data,
   output logic              outbuf_full,
   output logic              almost_full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              wr_acc;
   logic              rd_acc;

   // Flags come from the registered count only, so no input reaches them combinationally.
   assign outbuf_full = (count == FULL_CNT);
   assign empty       = (count == '0);
   assign almost_full = (count >= AF_CNT);

   assign wr_acc = outbuf_write & ~outbuf_full;
   assign rd_acc = rd_en & ~empty;

   // NOTE: the storage array has no reset; resetting it would turn the RAM into
   // DEPTH*DATA_W flops, and pointer/count reset already makes old contents unreachable.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // Pointer width equals log2(DEPTH), so increments wrap with no gap.
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         rd_valid <= rd_acc;

         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (outbuf_write && outbuf_full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_psum_out_fifo.sv
// Directed bench for psum_out_fifo: a queue-based reference model checked every
// cycle, plus literal expectations taken from the intended behaviour.
module tb_psum_out_fifo;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              outbuf_write = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              rd_en = 1'b0;
   logic              outbuf_full;
   logic              almost_full;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   int n_checks = 0;
   int n_errors = 0;

   psum_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .outbuf_write (outbuf_write),
      .wr_data      (wr_data),
      .outbuf_full  (outbuf_full),
      .almost_full  (almost_full),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .empty        (empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: contents as a queue, everything else follows from its size.
   logic [DATA_W-1:0] m_q[$];
   logic [DATA_W-1:0] m_rd_data = '0;
   logic              m_rd_valid = 1'b0;
   logic              m_overflow = 1'b0;
   logic              m_underflow = 1'b0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_q.delete();
            m_rd_data   = '0;
            m_rd_valid  = 1'b0;
            m_overflow  = 1'b0;
            m_underflow = 1'b0;
         end else begin
            automatic int  sz    = m_q.size();
            automatic bit  rd_ok = rd_en && (sz > 0);
            automatic bit  wr_ok = outbuf_write && (sz < DEPTH);
            if (outbuf_write && sz == DEPTH) m_overflow = 1'b1;
            if (rd_en && sz == 0) m_underflow = 1'b1;
            m_rd_valid = rd_ok;
            if (rd_ok) m_rd_data = m_q.pop_front();
            if (wr_ok) m_q.push_back(wr_data);
         end
      end
   end

   bit cmp_on = 1'b0;

   always @(negedge clk) begin
      if (cmp_on && !rst) begin
         check("m_count",     32'(count),       32'(m_q.size()));
         check("m_empty",     32'(empty),       32'(m_q.size() == 0));
         check("m_full",      32'(outbuf_full), 32'(m_q.size() == DEPTH));
         check("m_afull",     32'(almost_full), 32'(m_q.size() >= DEPTH - 2));
         check("m_rd_valid",  32'(rd_valid),    32'(m_rd_valid));
         check("m_rd_data",   32'(rd_data),     32'(m_rd_data));
         check("m_overflow",  32'(overflow),    32'(m_overflow));
         check("m_underflow", 32'(underflow),   32'(m_underflow));
      end
   end

   // Drive one cycle of inputs; returns 1 time unit after the edge that used them.
   task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r);
      outbuf_write = w;
      wr_data      = d;
      rd_en        = r;
      @(posedge clk);
      #1;
      outbuf_write = 1'b0;
      rd_en        = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cmp_on = 1'b1;
      @(posedge clk);
      #1;

      // Idle after reset
      repeat (5) step(1'b0, '0, 1'b0);
      check("idle_empty",     32'(empty),       32'd1);
      check("idle_count",     32'(count),       32'd0);
      check("idle_full",      32'(outbuf_full), 32'd0);
      check("idle_rd_valid",  32'(rd_valid),    32'd0);
      check("idle_overflow",  32'(overflow),    32'd0);
      check("idle_underflow", 32'(underflow),   32'd0);

      // Fill to DEPTH, then one write too many
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, DATA_W'(i), 1'b0);
         if (i == 5) check("afull_after5", 32'(almost_full), 32'd0);
         if (i == 6) check("afull_after6", 32'(almost_full), 32'd1);
         if (i == 7) check("full_after7",  32'(outbuf_full), 32'd0);
      end
      check("full_after8",  32'(outbuf_full), 32'd1);
      check("count_after8", 32'(count),       32'd8);
      step(1'b1, 16'h0009, 1'b0);
      check("ovf_set",      32'(overflow),    32'd1);
      check("ovf_count",    32'(count),       32'd8);

      // Drain in order, then read once more while empty
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b0, '0, 1'b1);
         check("drain_valid", 32'(rd_valid), 32'd1);
         check("drain_data",  32'(rd_data),  32'(i));
         if (i == 1) check("full_drop", 32'(outbuf_full), 32'd0);
      end
      check("drain_empty", 32'(empty), 32'd1);
      step(1'b0, '0, 1'b0);
      check("drain_valid_off", 32'(rd_valid),  32'd0);
      check("drain_hold_data", 32'(rd_data),   32'h0008);
      check("pre_underflow",   32'(underflow), 32'd0);
      step(1'b0, '0, 1'b1);
      check("underflow_set",   32'(underflow), 32'd1);
      check("underflow_valid", 32'(rd_valid),  32'd0);

      // Fill to 4, then 20 cycles of simultaneous write+read across two wraps
      for (int k = 0; k < 4; k++) step(1'b1, DATA_W'(16'h0100 + k), 1'b0);
      for (int k = 0; k < 20; k++) begin
         step(1'b1, DATA_W'(16'h0104 + k), 1'b1);
         check("stream_count", 32'(count),    32'd4);
         check("stream_valid", 32'(rd_valid), 32'd1);
         check("stream_data",  32'(rd_data),  32'(16'h0100 + k));
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b0, '0, 1'b1);
         check("tail_data", 32'(rd_data), 32'(16'h0114 + k));
      end
      check("tail_empty", 32'(empty), 32'd1);

      // Write and read together while empty: no fall-through
      step(1'b1, 16'h00AA, 1'b1);
      check("wr_rd_empty_count", 32'(count),     32'd1);
      check("wr_rd_empty_valid", 32'(rd_valid),  32'd0);
      check("wr_rd_empty_uflow", 32'(underflow), 32'd1);
      step(1'b0, '0, 1'b1);
      check("aa_valid", 32'(rd_valid), 32'd1);
      check("aa_data",  32'(rd_data),  32'h00AA);

      // Async reset at count=5, between edges
      for (int k = 0; k < 5; k++) step(1'b1, DATA_W'(16'h0200 + k), 1'b0);
      check("pre_rst_count", 32'(count), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count",    32'(count),       32'd0);
      check("arst_empty",    32'(empty),       32'd1);
      check("arst_full",     32'(outbuf_full), 32'd0);
      check("arst_afull",    32'(almost_full), 32'd0);
      check("arst_rd_valid", 32'(rd_valid),    32'd0);
      check("arst_rd_data",  32'(rd_data),     32'd0);
      check("arst_overflow", 32'(overflow),    32'd0);
      check("arst_underflow",32'(underflow),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 16'h1234, 1'b0);
      check("post_rst_count", 32'(count), 32'd1);
      step(1'b0, '0, 1'b1);
      check("post_rst_valid", 32'(rd_valid), 32'd1);
      check("post_rst_data",  32'(rd_data),  32'h1234);
      step(1'b0, '0, 1'b0);

      @(negedge clk);
      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/psum_out_fifo.md
Name: psum_out_fifo

Overview:
- Output buffer that sits directly downstream of the partial-sum write controller.
- It consumes that controller's `outbuf_write` pulse and the finished psum word, stores the word in a synchronous FIFO, and returns `outbuf_full` so the controller can stall the pipeline.
- An external consumer (DMA or host-side reader) drains it through a registered read port.

Parameters:
- DATA_W, 16, width of one partial-sum word.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden).
- AF_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- outbuf_write  input  1  write request from the psum write controller.
- wr_data  input  DATA_W  psum word; sampled on the same edge as outbuf_write.
- outbuf_full  output  1  FIFO holds DEPTH entries; feeds the controller's stall logic.
- almost_full  output  1  count >= AF_LEVEL.
- rd_en  input  1  read request from the downstream consumer.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse; rd_data holds the word popped on the previous edge.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a write was attempted while full.
- underflow  output  1  sticky; a read was attempted while empty.

Behaviour:
- Reset (async, asserted at any time including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, outbuf_full=0, almost_full=0.
  - rd_valid=0, rd_data=0, overflow=0, underflow=0.
  - Storage array is not reset; contents are don't-care after reset.
- Write accept: wr_acc = outbuf_write & ~outbuf_full.
  - On accept, mem[wr_ptr] <= wr_data and wr_ptr increments modulo DEPTH.
- Read accept: rd_acc = rd_en & ~empty.
  - On accept, rd_data <= mem[rd_ptr], rd_ptr increments modulo DEPTH, and rd_valid=1 on the next cycle.
  - Otherwise rd_valid=0 and rd_data holds its last value.
- Read latency: exactly 1 cycle from the accepting edge to rd_valid/rd_data.
- Count update:
  - count increments on wr_acc only.
  - count decrements on rd_acc only.
  - count is unchanged when both or neither occur.
- Simultaneous write and read:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: only the write is accepted. There is no fall-through; the new word is readable from the next cycle.
  - Full: only the read is accepted. The write is dropped and overflow sets; the controller must see outbuf_full and hold its data.
- Flags:
  - outbuf_full, empty and almost_full are decoded from count.
  - count is registered, so the flags carry no combinational path from outbuf_write or rd_en.
  - outbuf_full asserts the cycle after the accept that brings count to DEPTH.
  - outbuf_full deasserts the cycle after the read accept that brings count below DEPTH.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no gap. Data order is strictly FIFO across the wrap.
- overflow sets on (outbuf_write & outbuf_full).
- underflow sets on (rd_en & empty).
- Both sticky flags clear only on rst. A rejected request changes no pointer, no count and no data.
- Handshake contract with the upstream controller:
  - The controller asserts outbuf_write only while it samples outbuf_full=0.
  - This block asserts outbuf_full for as long as count==DEPTH, which keeps the controller in its wait/stall state.

Test Plan:
- Reset then idle 5 cycles → empty=1, count=0, outbuf_full=0, rd_valid=0, overflow=0, underflow=0.
- Write 0x0001..0x0008 on consecutive cycles (DEPTH=8):
  - almost_full=1 after the 6th write; outbuf_full=1 after the 8th write.
  - A 9th write of 0x0009 → overflow=1, count stays 8.
- Drain the full FIFO with rd_en held for 8 cycles:
  - rd_valid pulses 8 times carrying 0x0001..0x0008 in order, each 1 cycle after its read edge.
  - empty=1 afterwards; an extra rd_en → underflow=1.
- Fill to 4, then assert write and read together for 20 cycles with incrementing data:
  - count stays 4 and pointers wrap twice.
  - Read-out sequence continues in order with no loss or duplication.
- With the FIFO empty, assert write (0x00AA) and rd_en in the same cycle:
  - The write is accepted and the read is rejected; underflow=1 and count=1.
  - A read on the next cycle returns 0x00AA.
- At count=5, assert rst asynchronously between clock edges:
  - All outputs immediately return to their reset values.
  - After release, a write of 0x1234 followed by a read returns 0x1234.
